// File: rtl/rs_age_sel.sv
// Reservation station with CDB wakeup, same-cycle issue bypass and a single registered dispatch port.
// Define RS_AGE_ORDER_EN to dispatch the oldest ready entry; otherwise the lowest-index ready entry wins.
module rs_age_sel #(
    parameter int DEPTH   = 8,
    parameter int ROB_W   = 4,
    parameter int NUM_CDB = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       rob_clear_up,
    input  logic                       issue_valid,
    input  logic [6:0]                 op_type_in,
    input  logic [2:0]                 op_in,
    input  logic                       funct7b_in,
    input  logic [31:0]                v1_in,
    input  logic [31:0]                v2_in,
    input  logic                       dep1_in,
    input  logic                       dep2_in,
    input  logic [ROB_W-1:0]           tag1_in,
    input  logic [ROB_W-1:0]           tag2_in,
    input  logic [ROB_W-1:0]           rd_rob_in,
    input  logic [31:0]                pc_in,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]   cdb_tag,
    input  logic [NUM_CDB*32-1:0]      cdb_value,
    output logic                       exe_valid,
    output logic [6:0]                 exe_op_type,
    output logic [2:0]                 exe_op,
    output logic                       exe_funct7b,
    output logic [31:0]                exe_v1,
    output logic [31:0]                exe_v2,
    output logic [ROB_W-1:0]           exe_rob,
    output logic [31:0]                exe_pc,
    input  logic                       exe_ready,
    output logic                       is_full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Bit 32 flags a hit; the lowest-numbered matching channel supplies the value.
    function automatic logic [32:0] f_wake(
        input logic [ROB_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       vld,
        input logic [NUM_CDB*ROB_W-1:0] tags,
        input logic [NUM_CDB*32-1:0]    vals
    );
        logic [32:0] res;
        res = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (vld[k] && (tags[k*ROB_W +: ROB_W] == tag)) begin
                res = {1'b1, vals[k*32 +: 32]};
            end
        end
        return res;
    endfunction

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] r_dep1;
    logic [DEPTH-1:0] r_dep2;
    logic [6:0]       r_op_type [DEPTH];
    logic [2:0]       r_op      [DEPTH];
    logic             r_funct7b [DEPTH];
    logic [31:0]      r_v1      [DEPTH];
    logic [31:0]      r_v2      [DEPTH];
    logic [ROB_W-1:0] r_tag1    [DEPTH];
    logic [ROB_W-1:0] r_tag2    [DEPTH];
    logic [ROB_W-1:0] r_rob     [DEPTH];
    logic [31:0]      r_pc      [DEPTH];

    logic [32:0]      w_wake1 [DEPTH];
    logic [32:0]      w_wake2 [DEPTH];
    logic [32:0]      w_iwake1;
    logic [32:0]      w_iwake2;
    logic [DEPTH-1:0] w_ready;
    logic [IDX_W-1:0] w_free_idx;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_sel_any;
    logic [CNT_W-1:0] w_count;
    logic             w_accept;
    logic             w_out_free;
    logic             w_dispatch;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wake
            assign w_wake1[gi] = f_wake(r_tag1[gi], cdb_valid, cdb_tag, cdb_value);
            assign w_wake2[gi] = f_wake(r_tag2[gi], cdb_valid, cdb_tag, cdb_value);
        end
    endgenerate

    assign w_iwake1 = f_wake(tag1_in, cdb_valid, cdb_tag, cdb_value);
    assign w_iwake2 = f_wake(tag2_in, cdb_valid, cdb_tag, cdb_value);
    assign w_ready  = r_busy & ~r_dep1 & ~r_dep2;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + CNT_W'(r_busy[i]);
        end
    end

    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign count      = w_count;
    assign is_full    = (w_count == CNT_W'(DEPTH));
    assign w_accept   = rdy_in && !rob_clear_up && issue_valid && !is_full;
    assign w_out_free = !exe_valid || exe_ready;
    assign w_dispatch = rdy_in && !rob_clear_up && w_out_free && w_sel_any;

`ifdef RS_AGE_ORDER_EN
    // r_age[i][j] set means entry i was issued before entry j.
    logic [DEPTH-1:0] r_age [DEPTH];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_age[i] <= '0;
            end
        end else if (w_accept) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_age[w_free_idx][j] <= 1'b0;
                r_age[j][w_free_idx] <= 1'b1;
            end
        end
    end

    always_comb begin
        logic [DEPTH-1:0] v_self;
        w_sel_any = 1'b0;
        w_sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_self    = '0;
            v_self[i] = 1'b1;
            if (!w_sel_any && w_ready[i] && ((w_ready & ~r_age[i] & ~v_self) == '0)) begin
                w_sel_any = 1'b1;
                w_sel_idx = IDX_W'(i);
            end
        end
    end
`else
    always_comb begin
        w_sel_any = 1'b0;
        w_sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel_any = 1'b1;
                w_sel_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy <= '0;
            r_dep1 <= '0;
            r_dep2 <= '0;
        end else if (rdy_in) begin
            if (rob_clear_up) begin
                r_busy <= '0;
                r_dep1 <= '0;
                r_dep2 <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_accept && (w_free_idx == IDX_W'(i))) begin
                        r_busy[i] <= 1'b1;
                        r_dep1[i] <= dep1_in && !w_iwake1[32];
                        r_dep2[i] <= dep2_in && !w_iwake2[32];
                    end else begin
                        if (w_dispatch && (w_sel_idx == IDX_W'(i))) begin
                            r_busy[i] <= 1'b0;
                        end
                        if (r_dep1[i] && w_wake1[i][32]) begin
                            r_dep1[i] <= 1'b0;
                        end
                        if (r_dep2[i] && w_wake2[i][32]) begin
                            r_dep2[i] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Payload needs no reset: r_busy/r_dep* alone define what is valid.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !rob_clear_up) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_accept && (w_free_idx == IDX_W'(i))) begin
                    r_op_type[i] <= op_type_in;
                    r_op[i]      <= op_in;
                    r_funct7b[i] <= funct7b_in;
                    r_v1[i]      <= (dep1_in && w_iwake1[32]) ? w_iwake1[31:0] : v1_in;
                    r_v2[i]      <= (dep2_in && w_iwake2[32]) ? w_iwake2[31:0] : v2_in;
                    r_tag1[i]    <= tag1_in;
                    r_tag2[i]    <= tag2_in;
                    r_rob[i]     <= rd_rob_in;
                    r_pc[i]      <= pc_in;
                end else begin
                    if (r_dep1[i] && w_wake1[i][32]) begin
                        r_v1[i] <= w_wake1[i][31:0];
                    end
                    if (r_dep2[i] && w_wake2[i][32]) begin
                        r_v2[i] <= w_wake2[i][31:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            exe_valid   <= 1'b0;
            exe_op_type <= '0;
            exe_op      <= '0;
            exe_funct7b <= 1'b0;
            exe_v1      <= '0;
            exe_v2      <= '0;
            exe_rob     <= '0;
            exe_pc      <= '0;
        end else if (rdy_in) begin
            if (rob_clear_up) begin
                exe_valid <= 1'b0;
            end else if (w_out_free) begin
                exe_valid <= w_sel_any;
                if (w_sel_any) begin
                    exe_op_type <= r_op_type[w_sel_idx];
                    exe_op      <= r_op[w_sel_idx];
                    exe_funct7b <= r_funct7b[w_sel_idx];
                    exe_v1      <= r_v1[w_sel_idx];
                    exe_v2      <= r_v2[w_sel_idx];
                    exe_rob     <= r_rob[w_sel_idx];
                    exe_pc      <= r_pc[w_sel_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_age_sel.sv
// Directed testbench for rs_age_sel: latency, CDB wakeup/priority/bypass, full, stall, flush, freeze, order, reset.
module tb_rs_age_sel;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in, rob_clear_up, issue_valid;
    logic [6:0]  op_type_in;
    logic [2:0]  op_in;
    logic        funct7b_in;
    logic [31:0] v1_in, v2_in, pc_in;
    logic        dep1_in, dep2_in;
    logic [3:0]  tag1_in, tag2_in, rd_rob_in;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_value;
    logic        exe_valid, exe_funct7b, exe_ready, is_full;
    logic [6:0]  exe_op_type;
    logic [2:0]  exe_op;
    logic [31:0] exe_v1, exe_v2, exe_pc;
    logic [3:0]  exe_rob;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    rs_age_sel #(.DEPTH(8), .ROB_W(4), .NUM_CDB(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear_up(rob_clear_up),
        .issue_valid(issue_valid), .op_type_in(op_type_in), .op_in(op_in), .funct7b_in(funct7b_in),
        .v1_in(v1_in), .v2_in(v2_in), .dep1_in(dep1_in), .dep2_in(dep2_in),
        .tag1_in(tag1_in), .tag2_in(tag2_in), .rd_rob_in(rd_rob_in), .pc_in(pc_in),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .exe_valid(exe_valid), .exe_op_type(exe_op_type), .exe_op(exe_op), .exe_funct7b(exe_funct7b),
        .exe_v1(exe_v1), .exe_v2(exe_v2), .exe_rob(exe_rob), .exe_pc(exe_pc),
        .exe_ready(exe_ready), .is_full(is_full), .count(count)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rdy_in = 1'b1; rob_clear_up = 1'b0; issue_valid = 1'b0; exe_ready = 1'b1;
        op_type_in = '0; op_in = '0; funct7b_in = 1'b0; v1_in = '0; v2_in = '0; pc_in = '0;
        dep1_in = 1'b0; dep2_in = 1'b0; tag1_in = '0; tag2_in = '0; rd_rob_in = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    endtask

    task automatic put(input logic [6:0] ot, input logic [31:0] a, input logic [31:0] b,
                       input logic d1, input logic [3:0] t1, input logic d2, input logic [3:0] t2,
                       input logic [3:0] rob);
        issue_valid = 1'b1; op_type_in = ot; op_in = 3'd2; funct7b_in = 1'b1;
        v1_in = a; v2_in = b; dep1_in = d1; tag1_in = t1; dep2_in = d2; tag2_in = t2;
        rd_rob_in = rob; pc_in = 32'h1000 + a;
    endtask

    task automatic test_reset();
        idle();
        rst_in = 1'b1;
        repeat (2) tick();
        total++; if (exe_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", exe_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (is_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0h want=0", is_full); end
        total++; if (exe_v1 !== 32'h0 || exe_pc !== 32'h0) begin bad++; $display("FAIL reset_data got v1=%0h pc=%0h want 0", exe_v1, exe_pc); end
        rst_in = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_latency();
        put(7'h33, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
        tick();
        issue_valid = 1'b0;
        total++; if (count !== 4'd1) begin bad++; $display("FAIL lat_count1 got=%0d want=1", count); end
        total++; if (exe_valid !== 1'b0) begin bad++; $display("FAIL lat_early got=%0h want=0", exe_valid); end
        tick();
        total++; if (exe_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%0h want=1", exe_valid); end
        total++; if (exe_v1 !== 32'd5 || exe_v2 !== 32'd7) begin bad++; $display("FAIL lat_vals got=%0h/%0h want=5/7", exe_v1, exe_v2); end
        total++; if (exe_op_type !== 7'h33 || exe_rob !== 4'd9 || exe_pc !== 32'h1005) begin
            bad++; $display("FAIL lat_fields got ot=%0h rob=%0h pc=%0h want 33/9/1005", exe_op_type, exe_rob, exe_pc); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL lat_freed got=%0d want=0", count); end
        tick();
        total++; if (exe_valid !== 1'b0) begin bad++; $display("FAIL lat_drain got=%0h want=0", exe_valid); end
        $display("test_latency done");
    endtask

    task automatic test_cdb_priority();
        put(7'h13, 32'h0, 32'h22, 1'b1, 4'd3, 1'b0, 4'd0, 4'd1);
        tick();
        idle();
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd4}; cdb_value = {32'h0, 32'hCC};
        tick();
        idle();
        tick();
        total++; if (exe_valid !== 1'b0 || count !== 4'd1) begin
            bad++; $display("FAIL cdb_wrongtag got valid=%0h count=%0d want 0/1", exe_valid, count); end
        cdb_valid = 2'b11; cdb_tag = {4'd3, 4'd3}; cdb_value = {32'hBB, 32'hAA};
        tick();
        idle();
        total++; if (exe_valid !== 1'b0) begin bad++; $display("FAIL cdb_early got=%0h want=0", exe_valid); end
        tick();
        total++; if (exe_valid !== 1'b1) begin bad++; $display("FAIL cdb_valid got=%0h want=1", exe_valid); end
        total++; if (exe_v1 !== 32'hAA || exe_v2 !== 32'h22) begin bad++; $display("FAIL cdb_prio got=%0h/%0h want=aa/22", exe_v1, exe_v2); end
        tick();
        $display("test_cdb_priority done");
    endtask

    task automatic test_bypass();
        put(7'h33, 32'h1, 32'h0, 1'b0, 4'd0, 1'b1, 4'd6, 4'd2);
        cdb_valid = 2'b10; cdb_tag = {4'd6, 4'd0}; cdb_value = {32'h10, 32'h0};
        tick();
        idle();
        total++; if (exe_valid !== 1'b0 || count !== 4'd1) begin
            bad++; $display("FAIL byp_stage1 got valid=%0h count=%0d want 0/1", exe_valid, count); end
        tick();
        total++; if (exe_valid !== 1'b1 || exe_v2 !== 32'h10 || exe_v1 !== 32'h1) begin
            bad++; $display("FAIL byp_out got valid=%0h v1=%0h v2=%0h want 1/1/10", exe_valid, exe_v1, exe_v2); end
        tick();
        $display("test_bypass done");
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            put(7'h33, 32'(i), 32'h0, 1'b1, 4'(i), 1'b0, 4'd0, 4'(i));
            tick();
        end
        total++; if (count !== 4'd8 || is_full !== 1'b1) begin
            bad++; $display("FAIL full_fill got count=%0d full=%0h want 8/1", count, is_full); end
        put(7'h33, 32'h99, 32'h9, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
        tick();
        total++; if (count !== 4'd8 || exe_valid !== 1'b0) begin
            bad++; $display("FAIL full_reject got count=%0d valid=%0h want 8/0", count, exe_valid); end
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd0}; cdb_value = {32'h0, 32'h50};
        tick();
        cdb_valid = 2'b00;
        total++; if (count !== 4'd8) begin bad++; $display("FAIL full_wake got=%0d want=8", count); end
        tick();
        total++; if (count !== 4'd7 || exe_valid !== 1'b1 || exe_v1 !== 32'h50) begin
            bad++; $display("FAIL full_disp got count=%0d valid=%0h v1=%0h want 7/1/50", count, exe_valid, exe_v1); end
        tick();
        issue_valid = 1'b0;
        total++; if (count !== 4'd8 || exe_valid !== 1'b0) begin
            bad++; $display("FAIL full_accept got count=%0d valid=%0h want 8/0", count, exe_valid); end
        tick();
        total++; if (exe_valid !== 1'b1 || exe_v1 !== 32'h99 || count !== 4'd7) begin
            bad++; $display("FAIL full_ninth got valid=%0h v1=%0h count=%0d want 1/99/7", exe_valid, exe_v1, count); end
        rob_clear_up = 1'b1;
        tick();
        rob_clear_up = 1'b0;
        total++; if (count !== 4'd0 || exe_valid !== 1'b0) begin
            bad++; $display("FAIL full_flush got count=%0d valid=%0h want 0/0", count, exe_valid); end
        $display("test_full done");
    endtask

    task automatic test_stall();
        exe_ready = 1'b0;
        put(7'h33, 32'h11, 32'h1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        tick();
        put(7'h33, 32'h22, 32'h2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
        tick();
        issue_valid = 1'b0;
        total++; if (exe_valid !== 1'b1 || exe_v1 !== 32'h11 || count !== 4'd1) begin
            bad++; $display("FAIL stall_load got valid=%0h v1=%0h count=%0d want 1/11/1", exe_valid, exe_v1, count); end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (exe_valid !== 1'b1 || exe_v1 !== 32'h11 || exe_pc !== 32'h1011 || count !== 4'd1) begin
                bad++; $display("FAIL stall_hold%0d got valid=%0h v1=%0h pc=%0h count=%0d want 1/11/1011/1", c, exe_valid, exe_v1, exe_pc, count); end
        end
        rob_clear_up = 1'b1;
        tick();
        rob_clear_up = 1'b0;
        exe_ready = 1'b1;
        total++; if (exe_valid !== 1'b0 || count !== 4'd0) begin
            bad++; $display("FAIL stall_flush got valid=%0h count=%0d want 0/0", exe_valid, count); end
        $display("test_stall done");
    endtask

    task automatic test_freeze();
        rdy_in = 1'b0;
        put(7'h33, 32'h44, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
        tick();
        total++; if (count !== 4'd0 || exe_valid !== 1'b0) begin
            bad++; $display("FAIL frz_issue got count=%0d valid=%0h want 0/0", count, exe_valid); end
        rdy_in = 1'b1;
        put(7'h33, 32'h0, 32'h0, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5);
        tick();
        issue_valid = 1'b0;
        rdy_in = 1'b0;
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd2}; cdb_value = {32'h0, 32'h77};
        tick();
        cdb_valid = 2'b00;
        rdy_in = 1'b1;
        tick();
        tick();
        total++; if (exe_valid !== 1'b0 || count !== 4'd1) begin
            bad++; $display("FAIL frz_lostwake got valid=%0h count=%0d want 0/1", exe_valid, count); end
        rob_clear_up = 1'b1;
        tick();
        idle();
        $display("test_freeze done");
    endtask

    task automatic test_order();
        logic [31:0] first_v1;
        logic [31:0] second_v1;
`ifdef RS_AGE_ORDER_EN
        first_v1 = 32'hA0; second_v1 = 32'hB0;
`else
        first_v1 = 32'hB0; second_v1 = 32'hA0;
`endif
        for (int i = 0; i < 5; i++) begin
            put(7'h33, 32'(i), 32'h0, 1'b1, 4'd7, 1'b0, 4'd0, 4'(i));
            tick();
        end
        put(7'h33, 32'hA0, 32'h0, 1'b0, 4'd0, 1'b1, 4'd10, 4'd10);
        tick();
        idle();
        total++; if (count !== 4'd6) begin bad++; $display("FAIL ord_fill got=%0d want=6", count); end
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd7}; cdb_value = {32'h0, 32'h70};
        tick();
        cdb_valid = 2'b00;
        repeat (6) tick();
        total++; if (count !== 4'd1 || exe_valid !== 1'b0) begin
            bad++; $display("FAIL ord_drain got count=%0d valid=%0h want 1/0", count, exe_valid); end
        put(7'h33, 32'hB0, 32'h0, 1'b0, 4'd0, 1'b1, 4'd10, 4'd11);
        tick();
        idle();
        total++; if (count !== 4'd2) begin bad++; $display("FAIL ord_b got=%0d want=2", count); end
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd10}; cdb_value = {32'h0, 32'h33};
        tick();
        cdb_valid = 2'b00;
        tick();
        total++; if (exe_valid !== 1'b1 || exe_v1 !== first_v1) begin
            bad++; $display("FAIL ord_first got valid=%0h v1=%0h want 1/%0h", exe_valid, exe_v1, first_v1); end
        tick();
        total++; if (exe_valid !== 1'b1 || exe_v1 !== second_v1 || exe_v2 !== 32'h33) begin
            bad++; $display("FAIL ord_second got valid=%0h v1=%0h v2=%0h want 1/%0h/33", exe_valid, exe_v1, exe_v2, second_v1); end
        tick();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL ord_empty got=%0d want=0", count); end
        $display("test_order done");
    endtask

    task automatic test_reset_mid();
        put(7'h33, 32'h55, 32'h5, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6);
        tick();
        put(7'h33, 32'h66, 32'h6, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
        tick();
        idle();
        total++; if (exe_valid !== 1'b1 || count !== 4'd1) begin
            bad++; $display("FAIL rmid_pre got valid=%0h count=%0d want 1/1", exe_valid, count); end
        #2 rst_in = 1'b1;
        #1;
        total++; if (exe_valid !== 1'b0 || count !== 4'd0 || exe_v1 !== 32'h0) begin
            bad++; $display("FAIL rmid_async got valid=%0h count=%0d v1=%0h want 0/0/0", exe_valid, count, exe_v1); end
        tick();
        rst_in = 1'b0;
        tick();
        tick();
        total++; if (exe_valid !== 1'b0 || count !== 4'd0) begin
            bad++; $display("FAIL rmid_after got valid=%0h count=%0d want 0/0", exe_valid, count); end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_cdb_priority();
        test_bypass();
        test_full();
        test_stall();
        test_freeze();
        test_order();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
